// File: rtl/r4u4_twiddle_mult_if.sv
// r4u4_twiddle_mult_if: sample stream, segment config and twiddle-ROM port of r4u4_twiddle_mult.
// Mantissa/exponent widths come from MAN_WIDTH / EXP_WIDTH (defaults 16 / 6).
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif
interface r4u4_twiddle_mult_if;
   logic block_sync_i, next_sync_i, data_val_i;
   logic signed [`MAN_WIDTH-1:0] data_real_i, data_imag_i;
   logic signed [`EXP_WIDTH-1:0] data_exp_i;
   logic [3:0] ldn_rg_i;
   logic k1_i, k2_i;
   logic [10:0] tw_addr_o;
   logic signed [15:0] tw_cos_i, tw_sin_i;
   logic block_sync_o, next_sync_o, data_val_o;
   logic signed [`MAN_WIDTH-1:0] data_real_o, data_imag_o;
   logic signed [`EXP_WIDTH-1:0] data_exp_o;
   modport master (
      output block_sync_i, next_sync_i, data_val_i, data_real_i, data_imag_i, data_exp_i,
      output ldn_rg_i, k1_i, k2_i, tw_cos_i, tw_sin_i,
      input tw_addr_o, block_sync_o, next_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o
   );
   modport slave (
      input block_sync_i, next_sync_i, data_val_i, data_real_i, data_imag_i, data_exp_i,
      input ldn_rg_i, k1_i, k2_i, tw_cos_i, tw_sin_i,
      output tw_addr_o, block_sync_o, next_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o
   );
endinterface

// File: rtl/r4u4_twiddle_mult.sv
// r4u4_twiddle_mult: radix-2^2 inter-stage twiddle multiplier on block-floating-point samples, latency 4.
// Option TW_QUARTER_ROM_EN: the ROM holds N/4 entries and the quadrant is restored here.
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif
module r4u4_twiddle_mult (
   input logic clk_sys,
   input logic rst_sys,
   r4u4_twiddle_mult_if.slave bus
);
   localparam int MW = `MAN_WIDTH;
   localparam int EW = `EXP_WIDTH;
   localparam int PW = MW + 18;
   localparam int RW = MW + 4;
   localparam logic signed [RW-1:0] MAX_MAN = RW'((1 << (MW - 1)) - 1);
   typedef struct packed {
      logic v, bs, ns, byp;
      logic signed [MW-1:0] xr, xi;
      logic signed [EW-1:0] xe;
   } ctl_t;
   function automatic logic signed [RW-1:0] rnd(input logic signed [PW-1:0] v, input int sh);
      logic signed [PW-1:0] a;
      a = ((v[PW-1] ? -v : v) + (PW'(1) << (sh - 1))) >>> sh;
      return RW'(v[PW-1] ? -a : a);
   endfunction
   logic half;
   logic [8:0] n_q, n_cur, n_max;
   logic [1:0] m_q, m_cur;
   logic [10:0] prod, e_cur;
   ctl_t p [1:4];
   logic signed [16:0] c, s, wr, wi;
   logic signed [PW-1:0] pr_d, pi_d, pr3, pi3;
   logic signed [RW-1:0] rr4, ri4, ar, ai;
   logic ovf;
   assign half = bus.ldn_rg_i == 4'd10;
   assign n_max = half ? 9'd255 : 9'd511;
   assign n_cur = bus.next_sync_i || n_q >= n_max ? '0 : n_q + 9'd1;
   assign m_cur = bus.next_sync_i ? {bus.k2_i, bus.k1_i} : m_q;
   assign prod = 11'(n_cur) * 11'(m_cur);
   assign e_cur = half ? {1'b0, prod[9:0]} : prod;
   assign c = 17'(bus.tw_cos_i);
   assign s = 17'(bus.tw_sin_i);
`ifdef TW_QUARTER_ROM_EN
   logic [1:0] q1, q2;
   // rotate the first-quadrant ROM pair into the quadrant of e
   assign wr = q2 == 2'd0 ? c : q2 == 2'd1 ? -s : q2 == 2'd2 ? -c : s;
   assign wi = q2 == 2'd0 ? -s : q2 == 2'd1 ? -c : q2 == 2'd2 ? s : c;
`else
   assign wr = c;
   assign wi = -s;
`endif
   assign pr_d = PW'($signed(p[2].xr)) * PW'(wr) - PW'($signed(p[2].xi)) * PW'(wi);
   assign pi_d = PW'($signed(p[2].xr)) * PW'(wi) + PW'($signed(p[2].xi)) * PW'(wr);
   assign ar = rr4[RW-1] ? -rr4 : rr4;
   assign ai = ri4[RW-1] ? -ri4 : ri4;
   assign ovf = ar > MAX_MAN || ai > MAX_MAN;
   always_ff @(posedge clk_sys or posedge rst_sys)
      if (rst_sys) begin
         n_q <= '0;
         m_q <= '0;
         for (int i = 1; i <= 4; i++) p[i] <= '0;
`ifdef TW_QUARTER_ROM_EN
         q1 <= '0;
         q2 <= '0;
`endif
         pr3 <= '0;
         pi3 <= '0;
         rr4 <= '0;
         ri4 <= '0;
         bus.tw_addr_o <= '0;
         bus.block_sync_o <= 1'b0;
         bus.next_sync_o <= 1'b0;
         bus.data_val_o <= 1'b0;
         bus.data_real_o <= '0;
         bus.data_imag_o <= '0;
         bus.data_exp_o <= '0;
      end else begin
         if (bus.data_val_i) begin
            n_q <= n_cur;
            m_q <= m_cur;
         end
         p[1] <= '{v: bus.data_val_i, bs: bus.data_val_i & bus.block_sync_i, ns: bus.data_val_i & bus.next_sync_i,
                   byp: e_cur == '0, xr: bus.data_real_i, xi: bus.data_imag_i, xe: bus.data_exp_i};
         for (int i = 2; i <= 4; i++) p[i] <= p[i-1];
`ifdef TW_QUARTER_ROM_EN
         bus.tw_addr_o <= half ? {3'b0, e_cur[7:0]} : {2'b0, e_cur[8:0]};
         q1 <= half ? e_cur[9:8] : e_cur[10:9];
         q2 <= q1;
`else
         bus.tw_addr_o <= e_cur;
`endif
         pr3 <= pr_d;
         pi3 <= pi_d;
         rr4 <= rnd(pr3, 15);
         ri4 <= rnd(pi3, 15);
         bus.block_sync_o <= p[4].bs;
         bus.next_sync_o <= p[4].ns;
         bus.data_val_o <= p[4].v;
         bus.data_real_o <= !p[4].v ? '0 : p[4].byp ? p[4].xr : ovf ? MW'(rnd(PW'(rr4), 1)) : MW'(rr4);
         bus.data_imag_o <= !p[4].v ? '0 : p[4].byp ? p[4].xi : ovf ? MW'(rnd(PW'(ri4), 1)) : MW'(ri4);
         bus.data_exp_o <= !p[4].v ? '0 : p[4].byp || !ovf ? p[4].xe : p[4].xe + EW'(1);
      end
endmodule

// File: tb/tb_r4u4_twiddle_mult.sv
// tb_r4u4_twiddle_mult: randomized scoreboard bench for r4u4_twiddle_mult against a complex-arithmetic model.
// The ROM model serves cos/sin of 2*pi*addr/N, which is consistent for both ROM builds.
module tb_r4u4_twiddle_mult;
   localparam real PI = 3.14159265358979323846;
`ifdef TW_QUARTER_ROM_EN
   localparam int ADDR384 = 256;
`else
   localparam int ADDR384 = 768;
`endif
   typedef struct { longint t; bit bs, ns; int xr, xi, xe, tol; } exp_t;
   logic clk_sys = 1'b0;
   logic rst_sys = 1'b0;
   int tests = 0;
   int fails = 0;
   longint cyc = 0;
   bit armed = 1'b0;
   int mn = 0;
   int mm = 0;
   exp_t sb[$];
   r4u4_twiddle_mult_if bus();
   r4u4_twiddle_mult dut (.clk_sys(clk_sys), .rst_sys(rst_sys), .bus(bus));
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;
   function automatic int qround(real x);
      return x < 0.0 ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
   endfunction
   function automatic int n_of(logic [3:0] ldn);
      return ldn == 4'd10 ? 1024 : 2048;
   endfunction
   always @(posedge clk_sys) begin
      bus.tw_cos_i <= 16'(qround(32767.0 * $cos(2.0 * PI * real'(bus.tw_addr_o) / real'(n_of(bus.ldn_rg_i)))));
      bus.tw_sin_i <= 16'(qround(32767.0 * $sin(2.0 * PI * real'(bus.tw_addr_o) / real'(n_of(bus.ldn_rg_i)))));
   end
   task automatic chk(string nm, longint act, longint req, int tol);
      tests++;
      if (act > req + tol || act < req - tol) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", nm, act, req, tol, cyc);
      end
   endtask
   function automatic longint srnd(longint v, int sh);
      longint d = longint'(1) << sh;
      return v < 0 ? -((-v + d / 2) / d) : (v + d / 2) / d;
   endfunction
   // y = x * exp(-j*2*pi*e/N) with Q1.15 twiddles, then block-floating-point renormalisation
   function automatic exp_t model(longint t, bit bs, bit ns, int xr, int xi, int xe, int e, int nn);
      exp_t r;
      longint wr, wi, yr, yi;
      r.t = t; r.bs = bs; r.ns = ns; r.xr = xr; r.xi = xi; r.xe = xe; r.tol = 0;
      if (e != 0) begin
         wr = qround(32767.0 * $cos(2.0 * PI * e / nn));
         wi = -qround(32767.0 * $sin(2.0 * PI * e / nn));
         yr = srnd(xr * wr - xi * wi, 15);
         yi = srnd(xr * wi + xi * wr, 15);
         if (yr > 32767 || yr < -32767 || yi > 32767 || yi < -32767) begin
            yr = srnd(yr, 1);
            yi = srnd(yi, 1);
            r.xe = xe + 1;
         end
         r.xr = int'(yr);
         r.xi = int'(yi);
      end
      return r;
   endfunction
   function automatic int rman();
      int s = $urandom_range(0, 7);
      return s == 0 ? -32768 : s == 1 ? 32767 : int'($signed(16'($urandom)));
   endfunction
   task automatic drive(bit val, bit bs, bit ns, bit k1, bit k2, int xr, int xi, int xe);
      int nn;
      @(negedge clk_sys);
      bus.data_val_i = val;
      bus.block_sync_i = bs;
      bus.next_sync_i = ns;
      bus.k1_i = k1;
      bus.k2_i = k2;
      bus.data_real_i = 16'(xr);
      bus.data_imag_i = 16'(xi);
      bus.data_exp_i = 6'(xe);
      if (val) begin
         nn = n_of(bus.ldn_rg_i);
         if (ns) begin
            mn = 0;
            mm = int'(k1) + 2 * int'(k2);
         end else mn = (mn + 1) % (nn / 4);
         sb.push_back(model(cyc + 1, bs, ns, xr, xi, xe, (mn * mm) % nn, nn));
      end
   endtask
   task automatic expect_last(int xr, int xi, int xe, int tol);
      sb[$].xr = xr;
      sb[$].xi = xi;
      sb[$].xe = xe;
      sb[$].tol = tol;
   endtask
   task automatic idle(int k);
      repeat (k) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rman(), rman(), int'($urandom_range(0, 63)) - 32);
   endtask
   task automatic rand_sample(bit ns);
      drive(1'b1, $urandom_range(0, 15) == 0, ns, 1'($urandom), 1'($urandom), rman(), rman(), int'($urandom_range(0, 60)) - 31);
   endtask
   task automatic set_ldn(logic [3:0] v);
      idle(6);
      bus.ldn_rg_i = v;
   endtask
   task automatic do_reset();
      @(negedge clk_sys);
      bus.data_val_i = 1'b0;
      #2 rst_sys = 1'b1;
      #1 chk("reset_outputs", {bus.data_val_o, bus.block_sync_o, bus.next_sync_o, bus.data_real_o,
                               bus.data_imag_o, bus.data_exp_o, bus.tw_addr_o}, 0, 0);
      sb.delete();
      mn = 0;
      mm = 0;
      repeat (2) @(negedge clk_sys);
      #2 rst_sys = 1'b0;
      armed = 1'b1;
   endtask
   always @(negedge clk_sys) begin
      exp_t x;
      if (armed && !rst_sys) begin
         if (bus.data_val_o) begin
            if (sb.size() == 0) chk("unexpected_output", 1, 0, 0);
            else begin
               x = sb.pop_front();
               chk("latency", cyc - x.t, 4, 0);
               chk("block_sync", bus.block_sync_o, x.bs, 0);
               chk("next_sync", bus.next_sync_o, x.ns, 0);
               chk("data_real", bus.data_real_o, x.xr, x.tol);
               chk("data_imag", bus.data_imag_o, x.xi, x.tol);
               chk("data_exp", bus.data_exp_o, x.xe, 0);
            end
         end else
            chk("idle_zero", {bus.block_sync_o, bus.next_sync_o, bus.data_real_o, bus.data_imag_o, bus.data_exp_o}, 0, 0);
      end
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.data_val_i = 1'b0;
      bus.block_sync_i = 1'b0;
      bus.next_sync_i = 1'b0;
      bus.k1_i = 1'b0;
      bus.k2_i = 1'b0;
      bus.data_real_i = '0;
      bus.data_imag_i = '0;
      bus.data_exp_i = '0;
      bus.ldn_rg_i = 4'd11;
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1000, -2000, 3);
      expect_last(1000, -2000, 3, 0);
      repeat (8) rand_sample(1'b0);
      set_ldn(4'd10);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rman(), rman(), 0);
      repeat (127) rand_sample(1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16384, 0, 0);
      expect_last(11585, -11585, 0, 1);
      set_ldn(4'd11);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rman(), rman(), 0);
      repeat (255) rand_sample(1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32767, 32767, 2);
      expect_last(23170, 0, 3, 1);
      idle(6);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rman(), rman(), 1);
      repeat (383) rand_sample(1'b0);
      rand_sample(1'b0);
      idle(1);
      chk("tw_addr_n384_m2", bus.tw_addr_o, ADDR384, 0);
      idle(5);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rman(), rman(), 0);
      rand_sample(1'b0);
      idle(2);
      rand_sample(1'b0);
      repeat (4) begin
         rand_sample(1'b0);
         idle(1);
      end
      idle(6);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rman(), rman(), 0);
      repeat (10) rand_sample(1'b0);
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rman(), rman(), 5);
      repeat (20) rand_sample(1'b0);
      for (int s = 0; s < 12; s++) begin
         int len;
         len = s == 4 ? 600 : int'($urandom_range(20, 160));
         set_ldn(s % 4 == 0 ? 4'd10 : s % 4 == 1 ? 4'd11 : s % 4 == 2 ? 4'd0 : 4'd13);
         if (s == 4) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, rman(), rman(), 0);
         else rand_sample(1'b1);
         for (int i = 0; i < len; i++)
            if ($urandom_range(0, 3) == 0) idle(1);
            else rand_sample(s != 4 && $urandom_range(0, 60) == 0);
      end
      idle(10);
      chk("scoreboard_drained", sb.size(), 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/r4u4_twiddle_mult.md
R4U4_TWIDDLE_MULT -- requirements
Module: r4u4_twiddle_mult

Interface
REQ-001 SHALL expose: clk_sys  in  1  sole clock, all state on rising edge.
REQ-002 SHALL expose: rst_sys  in  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: block_sync_i, next_sync_i, data_val_i  in  1 each  upstream BF_II block start, segment start, sample valid.
REQ-004 SHALL expose: data_real_i, data_imag_i  in  `MAN_WIDTH signed; data_exp_i  in  `EXP_WIDTH signed  block-floating-point sample.
REQ-005 SHALL expose: ldn_rg_i  in  4  log2 N; 11 gives N=2048, 10 gives N=1024, any other value gives N=2048.
REQ-006 SHALL expose: k1_i, k2_i  in  1 each  segment index from BF_II.
REQ-007 SHALL expose: tw_addr_o  out  11  twiddle ROM address; tw_cos_i, tw_sin_i  in  16 signed  ROM data, Q1.15, registered, 1-cycle read latency.
REQ-008 SHALL expose: block_sync_o, next_sync_o, data_val_o  out  1 each; data_real_o, data_imag_o  out  `MAN_WIDTH signed; data_exp_o  out  `EXP_WIDTH signed.

Function
REQ-009 SHALL keep sample counter n (0..N/4-1): on data_val_i with next_sync_i, n=0 and m=k1_i+2*k2_i is latched; on other valid samples n increments, wrapping from N/4-1 to 0.
REQ-010 SHALL form twiddle exponent e=(n*m) mod N; twiddle W=cos(2*pi*e/N) - j*sin(2*pi*e/N).
REQ-011 SHALL output y = x*W: real = xr*wr - xi*wi, imag = xr*wi + xi*wr, full-precision products, symmetric rounding by 15 bits.
REQ-012 SHALL normalise: if max(|real|,|imag|) > 2^(`MAN_WIDTH-1)-1, symmetric-round both parts by 1 more bit and set exponent = data_exp_i+1; otherwise exponent = data_exp_i.
REQ-013 SHALL bypass when e==0: output equals input mantissas and exponent exactly.
REQ-014 SHALL have fixed latency of 4 clk_sys cycles: input sampled at edge t appears on outputs after edge t+4; block_sync, next_sync and data_val are delayed identically.
REQ-015 SHALL accept data_val_i gaps of any length; n and m SHALL hold during gaps. There is no backpressure.
REQ-016 SHALL drive data_real_o, data_imag_o and data_exp_o to 0 in any cycle where data_val_o=0.
REQ-017 SHALL treat next_sync_i arriving mid-segment as a restart: n=0 and m is re-latched, with no error flagged.
REQ-018 SHALL ignore next_sync_i and block_sync_i when data_val_i=0.

Reset
REQ-019 SHALL clear all outputs, n, m and the pipeline valid/sync bits to 0 immediately on rst_sys=1, including mid-stream; the first sample after release SHALL appear 4 cycles after it is accepted.

Configuration
REQ-020 SHALL support macro TW_QUARTER_ROM_EN.
  - Defined: ROM holds N/4 entries; tw_addr_o = e mod (N/4); quadrant q = e div (N/4).
  - Twiddle (wr,wi) from ROM values c,s: q0 (c,-s); q1 (-s,-c); q2 (-c,s); q3 (s,c).
  - Undefined: tw_addr_o = e; wr=tw_cos_i, wi=-tw_sin_i.
REQ-021 SHALL produce bit-identical data outputs in both builds, given consistent ROM contents.

Verification (MAN_WIDTH=16, EXP_WIDTH=6)
REQ-022 SHALL cover: m=0 segment, input (1000,-2000,exp 3) -> output (1000,-2000,3) exactly, 4 cycles later.
REQ-023 SHALL cover: N=1024, k1=1/k2=0, n=128, input (16384,0,0) -> output (11585,-11585,0) within ±1 LSB.
REQ-024 SHALL cover: N=2048, m=1, n=256, input (32767,32767,2) -> overflow; output (23170,0,3) within ±1 LSB.
REQ-025 SHALL cover: N=2048, m=2, n=384 -> tw_addr_o=256 with TW_QUARTER_ROM_EN and 768 without; data identical in both builds.
REQ-026 SHALL cover: data_val_i toggling 1,0,0,1 within a segment -> n advances only on valid samples; data_val_o pattern equals the input pattern delayed 4 cycles.
REQ-027 SHALL cover: rst_sys pulsed mid-segment -> all outputs 0 in the same cycle; after release, next_sync_i restarts the segment with n=0.
